// File: rtl/decode_wide_pkg.sv
// Shared decode types: fetch packet, uop, flush packet, and the RISC-V subset decoder.
// Latency: pure types and combinational helper functions.
// Backpressure: not applicable.
package decode_wide_pkg;

  localparam int DE_MAX_LANES = 4;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    U_ILLEGAL = 2'd0,
    U_ADD     = 2'd1,
    U_ADDI    = 2'd2,
    U_EBREAK  = 2'd3
  } t_uop;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef SIMULATION
    logic [31:0] simid;
`endif
  } t_instr_pkt;

  typedef struct packed {
    t_uop        op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
`ifdef SIMULATION
    logic [31:0] simid;
`endif
  } t_uinstr;

  typedef struct packed {
    logic        valid;
    logic [31:0] redirect_pc;
  } t_nuke_pkt;

  // Register fields are extracted unconditionally; only the opcode class is qualified.
  function automatic t_uinstr f_decode_rv_instr(input logic [31:0] instr);
    t_uinstr u;
    u     = '0;
    u.rd  = instr[11:7];
    u.rs1 = instr[19:15];
    u.rs2 = instr[24:20];
    u.imm = {{20{instr[31]}}, instr[31:20]};
    if (instr == EBREAK_INSTR)
      u.op = U_EBREAK;
    else if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'd0)
      u.op = U_ADD;
    else if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0)
      u.op = U_ADDI;
    else
      u.op = U_ILLEGAL;
    return u;
  endfunction

  // Index of the lowest set lane, or DE_MAX_LANES when no lane is set.
  function automatic int f_first_ebreak(input logic [DE_MAX_LANES-1:0] mask);
    int idx;
    idx = DE_MAX_LANES;
    for (int i = DE_MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/decode_wide_lane.sv
// decode_lane: one DE0 decode lane, raw instruction to uop with pc/simid carried through.
// Latency: combinational.
// Backpressure: none; the queue in decode_wide decides whether the result is kept.
module decode_lane
  import decode_wide_pkg::*;
(
  input  t_instr_pkt instr_pkt,
  output t_uinstr    uop,
  output logic       is_ebreak
);

  // Decode the instruction word and tag it with its fetch identity.
  always_comb begin
    uop    = f_decode_rv_instr(instr_pkt.instr);
    uop.pc = instr_pkt.pc;
`ifdef SIMULATION
    uop.simid = instr_pkt.simid;
`endif
    is_ebreak = (uop.op == U_EBREAK);
  end

endmodule

// File: rtl/decode_wide.sv
// decode_wide: decodes up to NIN instructions per cycle into an in-order multi-push/multi-pop uop queue.
// Latency: a uop pushed at edge N is visible to ucode in cycle N+1; there is no DE0->DE1 bypass.
// Backpressure: decode_ready_de0 only when a full NIN group fits (pre-pop count); ucode pops by num_ready_uc0 credits.
module decode_wide
  import decode_wide_pkg::*;
#(
  parameter int NIN         = 2,
  parameter int NOUT        = 2,
  parameter int DEPTH       = 8,
  parameter int EBREAK_STOP = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  t_nuke_pkt                  nuke_rb1,
  output logic                       decode_ready_de0,
  input  logic [NIN-1:0]             valid_fe1,
  input  t_instr_pkt [NIN-1:0]       instr_fe1,
  input  logic [$clog2(NOUT+1)-1:0]  num_ready_uc0,
  output logic [NOUT-1:0]            valid_de1,
  output t_uinstr [NOUT-1:0]         uinstr_de1,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_de1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  t_uinstr                 dec_uop [NIN];
  logic [NIN-1:0]          dec_ebreak;
  t_uinstr                 entry_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_next;
  logic                    ebreak_seen_q;
  logic                    ready_q;
  logic [DE_MAX_LANES-1:0] eb_mask;
  logic [NIN-1:0]          push;
  int                      first_eb;
  int                      npush;
  int                      npop;

  // Only the valid bit of the flush packet matters to decode.
  logic unused_nuke_bits;
  assign unused_nuke_bits = ^nuke_rb1.redirect_pc;

  for (genvar gi = 0; gi < NIN; gi++) begin : g_lane
    decode_lane u_lane (
      .instr_pkt (instr_fe1[gi]),
      .uop       (dec_uop[gi]),
      .is_ebreak (dec_ebreak[gi])
    );
  end

  // Ready is a register tracking the count, so it is low in reset and has no path from num_ready_uc0.
  assign decode_ready_de0 = ready_q;
  assign occupancy_de1    = count_q;

  // In-order push mask: the first valid EBREAK is kept, younger lanes in its group are dropped.
  always_comb begin
    eb_mask          = '0;
    eb_mask[NIN-1:0] = valid_fe1 & dec_ebreak;
    first_eb         = f_first_ebreak(eb_mask);
    push             = '0;
    npush            = 0;
    for (int i = 0; i < NIN; i++) begin
      push[i] = valid_fe1[i] && ready_q && !nuke_rb1.valid && !ebreak_seen_q
                && !((EBREAK_STOP != 0) && (i > first_eb));
      if (push[i]) npush = npush + 1;
    end
  end

  // Pop up to the granted credits from the oldest entries; a nuke suppresses the pop entirely.
  always_comb begin
    npop = int'(num_ready_uc0);
    if (npop > NOUT) npop = NOUT;
    if (npop > int'(count_q)) npop = int'(count_q);
    if (nuke_rb1.valid) npop = 0;
    for (int k = 0; k < NOUT; k++) begin
      valid_de1[k]  = (k < npop);
      uinstr_de1[k] = entry_q[rd_ptr_q + PW'(k)];
    end
    count_next = CW'(int'(count_q) + npush - npop);
  end

  // Queue state: storage, pointers, count, EBREAK stop flag and the registered ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < DEPTH; d++) entry_q[d] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ebreak_seen_q <= 1'b0;
      ready_q       <= 1'b0;
    end else if (nuke_rb1.valid) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ebreak_seen_q <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (push[i]) entry_q[wr_ptr_q + PW'(i)] <= dec_uop[i];
      end
      wr_ptr_q <= wr_ptr_q + PW'(npush);
      rd_ptr_q <= rd_ptr_q + PW'(npop);
      count_q  <= count_next;
      if ((EBREAK_STOP != 0) && |(push & dec_ebreak)) ebreak_seen_q <= 1'b1;
      ready_q  <= ((DEPTH - int'(count_next)) >= NIN);
    end
  end

`ifdef SIMULATION
  logic [31:0] instr_cnt;

  // Running total of uops accepted into the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instr_cnt <= '0;
    else          instr_cnt <= instr_cnt + 32'(npush);
  end
`endif

`ifdef ASSERT
  // Lane masks must be contiguous from lane 0; the queue can never over- or underflow.
  always @(posedge clk) begin
    if (reset_n) begin
      assert ((valid_fe1 & (valid_fe1 + NIN'(1))) == '0);
      assert ((int'(count_q) + npush) <= DEPTH);
      assert (npop <= int'(count_q));
    end
  end
`endif

endmodule

// File: tb/tb_decode_wide.sv
// Directed self-checking bench: vector table on a 2x2x8 build, plus wrap, single-lane and async-reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
// Each table row describes the state seen before that row's rising edge.
module tb_decode_wide;
  import decode_wide_pkg::*;

  localparam logic [31:0] ADD = 32'h003100B3;
  localparam logic [31:0] EBK = 32'h00100073;

  logic      clk = 1'b0;
  logic      reset_n;
  t_nuke_pkt nuke;

  always #5 clk = ~clk;

  // Main build: NIN=2, NOUT=2, DEPTH=8
  logic                 m_rdy;
  logic [1:0]           m_vin;
  t_instr_pkt [1:0]     m_instr;
  logic [1:0]           m_nr;
  logic [1:0]           m_vout;
  t_uinstr [1:0]        m_uop;
  logic [3:0]           m_occ;

  // Wrap build: NIN=1, NOUT=2, DEPTH=4
  logic                 w_rdy;
  logic [0:0]           w_vin;
  t_instr_pkt [0:0]     w_instr;
  logic [1:0]           w_nr;
  logic [1:0]           w_vout;
  t_uinstr [1:0]        w_uop;
  logic [2:0]           w_occ;

  // Single-lane build: NIN=1, NOUT=1, DEPTH=4
  logic                 s_rdy;
  logic [0:0]           s_vin;
  t_instr_pkt [0:0]     s_instr;
  logic [0:0]           s_nr;
  logic [0:0]           s_vout;
  t_uinstr [0:0]        s_uop;
  logic [2:0]           s_occ;

  decode_wide #(.NIN(2), .NOUT(2), .DEPTH(8), .EBREAK_STOP(1)) dut (
    .clk(clk), .reset_n(reset_n), .nuke_rb1(nuke), .decode_ready_de0(m_rdy),
    .valid_fe1(m_vin), .instr_fe1(m_instr), .num_ready_uc0(m_nr),
    .valid_de1(m_vout), .uinstr_de1(m_uop), .occupancy_de1(m_occ));

  decode_wide #(.NIN(1), .NOUT(2), .DEPTH(4), .EBREAK_STOP(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .nuke_rb1(nuke), .decode_ready_de0(w_rdy),
    .valid_fe1(w_vin), .instr_fe1(w_instr), .num_ready_uc0(w_nr),
    .valid_de1(w_vout), .uinstr_de1(w_uop), .occupancy_de1(w_occ));

  decode_wide #(.NIN(1), .NOUT(1), .DEPTH(4), .EBREAK_STOP(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .nuke_rb1(nuke), .decode_ready_de0(s_rdy),
    .valid_fe1(s_vin), .instr_fe1(s_instr), .num_ready_uc0(s_nr),
    .valid_de1(s_vout), .uinstr_de1(s_uop), .occupancy_de1(s_occ));

  typedef struct {
    logic [1:0]  vin;
    logic [31:0] i0, p0, i1, p1;
    logic [1:0]  nr;
    logic        nk;
    logic        rdy;
    logic [3:0]  occ;
    logic [1:0]  vout;
    logic [31:0] e0, e1;
    t_uop        op0, op1;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] vin, input logic [31:0] i0, input logic [31:0] p0,
                              input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] nr,
                              input logic nk, input logic rdy, input logic [3:0] occ,
                              input logic [1:0] vout, input logic [31:0] e0, input logic [31:0] e1,
                              input t_uop op0, input t_uop op1);
    vec_t r;
    r.vin = vin; r.i0 = i0; r.p0 = p0; r.i1 = i1; r.p1 = p1; r.nr = nr; r.nk = nk;
    r.rdy = rdy; r.occ = occ; r.vout = vout; r.e0 = e0; r.e1 = e1; r.op0 = op0; r.op1 = op1;
    return r;
  endfunction

  initial begin
    reset_n = 1'b0;
    nuke    = '0;
    m_vin = '0; m_instr = '0; m_nr = 2'd2;
    w_vin = '0; w_instr = '0; w_nr = '0;
    s_vin = '0; s_instr = '0; s_nr = '0;

    //           vin   i0   p0      i1   p1      nr nk  rdy occ vout  e0      e1      op0       op1
    // Fill to full with ucode stalled, then drain two per cycle.
    vq.push_back(mk(2'b11, ADD, 32'h00,  ADD, 32'h04,  0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h08,  ADD, 32'h0C,  0, 0, 1, 2, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h10,  ADD, 32'h14,  0, 0, 1, 4, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h18,  ADD, 32'h1C,  0, 0, 1, 6, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       0, 0, 0, 8, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h20,  ADD, 32'h24,  2, 0, 0, 8, 2'b11, 32'h00, 32'h04, U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 6, 2'b11, 32'h08, 32'h0C, U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 4, 2'b11, 32'h10, 32'h14, U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 2, 2'b11, 32'h18, 32'h1C, U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    // No bypass, then partial pops limited by credits and by count.
    vq.push_back(mk(2'b11, ADD, 32'h40,  ADD, 32'h44,  2, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       1, 0, 1, 2, 2'b01, 32'h40, 0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 1, 2'b01, 32'h44, 0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    // EBREAK in lane 1: it is kept, following groups are ignored until a nuke.
    vq.push_back(mk(2'b11, ADD, 32'h100, EBK, 32'h104, 0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b01, ADD, 32'h108, ADD, 0,       0, 0, 1, 2, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 2, 2'b11, 32'h100,32'h104,U_ADD,    U_EBREAK));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       0, 1, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b01, ADD, 32'h200, ADD, 0,       0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 1, 2'b01, 32'h200,0,      U_ADD,    U_ADD));
    // EBREAK in lane 0 drops the younger lane of the same group.
    vq.push_back(mk(2'b11, EBK, 32'h300, ADD, 32'h304, 0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b01, ADD, 32'h308, ADD, 0,       2, 0, 1, 1, 2'b01, 32'h300,0,      U_EBREAK, U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       0, 1, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    // Nuke with a simultaneous push and pop at occupancy 5.
    vq.push_back(mk(2'b11, ADD, 32'h400, ADD, 32'h404, 0, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h408, ADD, 32'h40C, 0, 0, 1, 2, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b01, ADD, 32'h410, ADD, 0,       0, 0, 1, 4, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b11, ADD, 32'h414, ADD, 32'h418, 2, 1, 1, 5, 2'b00, 0,      0,      U_ADD,    U_ADD));
    vq.push_back(mk(2'b00, ADD, 0,       ADD, 0,       2, 0, 1, 0, 2'b00, 0,      0,      U_ADD,    U_ADD));

    // Reset state, with ucode asking for two uops.
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 128'(m_rdy), 128'(1'b0));
    chk("reset occupancy", 128'(m_occ), 128'(4'd0));
    chk("reset valid_de1", 128'(m_vout), 128'(2'b00));
    @(negedge clk);
    reset_n = 1'b1;
    m_nr    = '0;
    @(negedge clk);

    // Table-driven vectors on the main build.
    for (int n = 0; n < vq.size(); n++) begin
      v = vq[n];
      m_vin = v.vin;
      m_instr[0].instr = v.i0; m_instr[0].pc = v.p0;
      m_instr[1].instr = v.i1; m_instr[1].pc = v.p1;
      m_nr = v.nr;
      nuke.valid = v.nk;
      #1;
      chk($sformatf("v%0d ready", n), 128'(m_rdy), 128'(v.rdy));
      chk($sformatf("v%0d occupancy", n), 128'(m_occ), 128'(v.occ));
      chk($sformatf("v%0d valid_de1", n), 128'(m_vout), 128'(v.vout));
      if (v.vout[0]) begin
        chk($sformatf("v%0d lane0 pc", n), 128'(m_uop[0].pc), 128'(v.e0));
        chk($sformatf("v%0d lane0 op", n), 128'(m_uop[0].op), 128'(v.op0));
      end
      if (v.vout[1]) begin
        chk($sformatf("v%0d lane1 pc", n), 128'(m_uop[1].pc), 128'(v.e1));
        chk($sformatf("v%0d lane1 op", n), 128'(m_uop[1].op), 128'(v.op1));
      end
      @(negedge clk);
    end
    m_vin = '0; m_nr = '0; nuke = '0;

    // Wrap: hold occupancy 3 in a 4-deep queue, one in and one out per cycle across the index wrap.
    for (int j = 0; j < 3; j++) begin
      w_vin = 1'b1; w_instr[0].instr = ADD; w_instr[0].pc = 32'(4 * j); w_nr = 2'd0;
      @(negedge clk);
    end
    for (int j = 0; j < 8; j++) begin
      w_vin = 1'b1; w_instr[0].instr = ADD; w_instr[0].pc = 32'(12 + 4 * j); w_nr = 2'd1;
      #1;
      chk($sformatf("wrap%0d occupancy", j), 128'(w_occ), 128'(3'd3));
      chk($sformatf("wrap%0d valid_de1", j), 128'(w_vout), 128'(2'b01));
      chk($sformatf("wrap%0d lane0 pc", j), 128'(w_uop[0].pc), 128'(4 * j));
      @(negedge clk);
    end
    w_vin = '0; w_nr = 2'd2;
    #1;
    chk("wrap drain0 valid_de1", 128'(w_vout), 128'(2'b11));
    chk("wrap drain0 lane0 pc", 128'(w_uop[0].pc), 128'(32'h20));
    chk("wrap drain0 lane1 pc", 128'(w_uop[1].pc), 128'(32'h24));
    @(negedge clk);
    #1;
    chk("wrap drain1 valid_de1", 128'(w_vout), 128'(2'b01));
    chk("wrap drain1 lane0 pc", 128'(w_uop[0].pc), 128'(32'h28));
    @(negedge clk);
    #1;
    chk("wrap drain2 occupancy", 128'(w_occ), 128'(3'd0));
    w_nr = '0;

    // Single lane: back-to-back push and pop sustains one uop per cycle, one cycle behind.
    for (int j = 0; j < 9; j++) begin
      s_vin = (j < 7) ? 1'b1 : 1'b0;
      s_instr[0].instr = ADD; s_instr[0].pc = 32'(32'h500 + 4 * j); s_nr = 1'b1;
      #1;
      chk($sformatf("single%0d valid_de1", j), 128'(s_vout), 128'((j > 0) && (j < 8)));
      chk($sformatf("single%0d occupancy", j), 128'(s_occ), 128'((j > 0) && (j < 8)));
      if (j > 0 && j < 8) chk($sformatf("single%0d pc", j), 128'(s_uop[0].pc), 128'(32'h500 + 4 * (j - 1)));
      @(negedge clk);
    end
    s_vin = '0; s_nr = '0;

    // Async reset mid-stream at occupancy 6.
    for (int g = 0; g < 3; g++) begin
      m_vin = 2'b11; m_nr = 2'd0;
      m_instr[0].instr = ADD; m_instr[0].pc = 32'(32'h600 + 8 * g);
      m_instr[1].instr = ADD; m_instr[1].pc = 32'(32'h604 + 8 * g);
      @(negedge clk);
    end
    m_vin = '0; m_nr = 2'd2;
    #1;
    chk("pre-reset occupancy", 128'(m_occ), 128'(4'd6));
    chk("pre-reset valid_de1", 128'(m_vout), 128'(2'b11));
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset valid_de1", 128'(m_vout), 128'(2'b00));
    chk("async reset occupancy", 128'(m_occ), 128'(4'd0));
    chk("async reset ready", 128'(m_rdy), 128'(1'b0));
    chk("async reset lane0 uop", 128'(m_uop[0]), 128'(0));
    chk("async reset lane1 uop", 128'(m_uop[1]), 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset ready", 128'(m_rdy), 128'(1'b1));
    chk("post-reset occupancy", 128'(m_occ), 128'(4'd0));
    chk("post-reset valid_de1", 128'(m_vout), 128'(2'b00));
    m_vin = 2'b11; m_nr = 2'd0;
    m_instr[0].instr = ADD; m_instr[0].pc = 32'h700;
    m_instr[1].instr = ADD; m_instr[1].pc = 32'h704;
    @(negedge clk);
    m_vin = '0; m_nr = 2'd2;
    #1;
    chk("post-reset valid_de1 after push", 128'(m_vout), 128'(2'b11));
    chk("post-reset lane0 pc", 128'(m_uop[0].pc), 128'(32'h700));
    chk("post-reset lane1 pc", 128'(m_uop[1].pc), 128'(32'h704));
    @(negedge clk);
    m_nr = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
